// File: rtl/signaal_meter.sv
// PWM meter: measures the high time and period of a synchronized input, strobing
// Geldig once per completed rise-to-rise period and raising a sticky Fout on timeout.
//
//   state | meaning
//   ------+-------------------------------------------------
//   WACHT | waiting for a first rise, partial periods ignored
//   HOOG  | input high, counting high time
//   LAAG  | input low after a high phase, counting period
module signaal_meter #(
  parameter int unsigned PERIODE_MAX = 30000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Invoer,
  output logic [15:0] Breedte,
  output logic [15:0] Periode,
  output logic        Geldig,
  output logic        Fout
);

  typedef enum logic [1:0] {WACHT, HOOG, LAAG} state_t;

  localparam logic [15:0] PMAX = 16'(PERIODE_MAX);

  state_t      state, state_nxt;
  logic        sync1, s, s_d;
  logic [15:0] cnt, hoog_cnt;
  logic        rise, fall, timeout;

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  // >= rather than == so a fall landing exactly on PMAX cannot let cnt run past it
  assign timeout = (state != WACHT) && (cnt >= PMAX) && !rise && !fall;

  always_ff @(posedge CLK) begin
    if (Reset) state <= WACHT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WACHT: if (rise) state_nxt = HOOG;
      HOOG: begin
        if (fall)         state_nxt = LAAG;
        else if (timeout) state_nxt = WACHT;
      end
      LAAG: begin
        if (rise)         state_nxt = HOOG;
        else if (timeout) state_nxt = WACHT;
      end
      default: state_nxt = WACHT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      s_d      <= 1'b0;
      cnt      <= '0;
      hoog_cnt <= '0;
      Breedte  <= '0;
      Periode  <= '0;
      Geldig   <= 1'b0;
      Fout     <= 1'b0;
    end else begin
      sync1  <= Invoer;
      s      <= sync1;
      s_d    <= s;
      Geldig <= 1'b0;

      if (rise)
        cnt <= 16'd1;
      else if (state != WACHT && !timeout)
        cnt <= cnt + 16'd1;

      if (state == HOOG && fall)
        hoog_cnt <= cnt;

      if (state == LAAG && rise) begin
        Breedte <= hoog_cnt;
        Periode <= cnt;
        Geldig  <= 1'b1;
        Fout    <= 1'b0;
      end else if (timeout) begin
        Fout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_signaal_meter.sv
// Directed bench for signaal_meter with a shortened timeout so every scenario
// stays within a few thousand cycles.
`timescale 1ns/1ps
module tb_signaal_meter;

  localparam int PM = 300;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Invoer;
  logic [15:0] Breedte, Periode;
  logic        Geldig, Fout;

  int tests = 0;
  int fails = 0;
  int gcount = 0;
  int lastb = 0, lastp = 0;
  int minb, maxb, minp, maxp;
  int g;

  signaal_meter #(.PERIODE_MAX(PM)) dut (
    .CLK(CLK), .Reset(Reset), .Invoer(Invoer),
    .Breedte(Breedte), .Periode(Periode), .Geldig(Geldig), .Fout(Fout)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (Geldig) begin
      gcount++;
      lastb = int'(Breedte);
      lastp = int'(Periode);
      if (lastb < minb) minb = lastb;
      if (lastb > maxb) maxb = lastb;
      if (lastp < minp) minp = lastp;
      if (lastp > maxp) maxp = lastp;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    Invoer = v;
    repeat (n) @(negedge CLK);
  endtask

  // toggle at a random phase n cycles after the previous toggle's grid edge
  task automatic jtog(input logic v, input int n);
    repeat (n) @(posedge CLK);
    #($urandom_range(1, 9));
    Invoer = v;
  endtask

  task automatic clr_track();
    minb = 65535; maxb = 0; minp = 65535; maxp = 0;
  endtask

  initial begin
    clr_track();
    Invoer = 1'b0;
    Reset  = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_breedte", int'(Breedte), 0);
    chk("rst_periode", int'(Periode), 0);
    chk("rst_geldig",  int'(Geldig), 0);
    chk("rst_fout",    int'(Fout), 0);
    Reset = 1'b0;
    hold(0, 5);

    // 60 high / 181 low, repeated
    g = gcount;
    repeat (3) begin
      hold(1, 60);
      hold(0, 181);
    end
    Invoer = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("lat_geldig_n2", int'(Geldig), 0);
    @(negedge CLK);
    chk("lat_geldig_n3", int'(Geldig), 1);
    @(negedge CLK);
    chk("lat_geldig_n4", int'(Geldig), 0);
    chk("a_count",   gcount - g, 3);
    chk("a_breedte", lastb, 60);
    chk("a_periode", lastp, 241);
    chk("a_fout",    int'(Fout), 0);

    // 1 high / 99 low; first rise closes the 4-high/50-low leftover period
    g = gcount;
    hold(0, 50);
    repeat (4) begin
      hold(1, 1);
      hold(0, 99);
    end
    hold(1, 4);
    chk("b_count",   gcount - g, 5);
    chk("b_breedte", lastb, 1);
    chk("b_periode", lastp, 100);
    chk("b_out_b",   int'(Breedte), 1);

    // held low: timeout, values retained, cleared by the next Geldig
    g = gcount;
    hold(0, 200);
    chk("c_fout_early", int'(Fout), 0);
    hold(0, 200);
    chk("c_fout_set",  int'(Fout), 1);
    chk("c_no_geldig", gcount - g, 0);
    chk("c_keep_b",    int'(Breedte), 1);
    chk("c_keep_p",    int'(Periode), 100);
    hold(1, 10);
    chk("c_fout_first_rise", int'(Fout), 1);
    hold(0, 20);
    hold(1, 4);
    chk("c_resume_count", gcount - g, 1);
    chk("c_resume_b",     lastb, 10);
    chk("c_resume_p",     lastp, 30);
    chk("c_fout_clear",   int'(Fout), 0);

    // rise exactly at cnt == PM is a valid period; one cycle later is a timeout
    hold(0, 20);
    hold(1, 50);
    hold(0, PM - 50);
    hold(1, 4);
    chk("d_edge_p",    lastp, PM);
    chk("d_edge_b",    lastb, 50);
    chk("d_edge_fout", int'(Fout), 0);
    g = gcount;
    hold(1, 46);
    hold(0, PM - 49);
    hold(1, 4);
    chk("d_over_count", gcount - g, 0);
    chk("d_over_fout",  int'(Fout), 1);
    chk("d_over_p",     int'(Periode), PM);

    // reset during HOOG discards the period in progress
    hold(1, 10);
    Reset  = 1'b1;
    Invoer = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    chk("e_rst_b",  int'(Breedte), 0);
    chk("e_rst_p",  int'(Periode), 0);
    chk("e_rst_f",  int'(Fout), 0);
    chk("e_rst_g",  int'(Geldig), 0);
    g = gcount;
    hold(0, 40);
    hold(1, 30);
    hold(0, 70);
    chk("e_no_early_geldig", gcount - g, 0);
    hold(1, 4);
    chk("e_count", gcount - g, 1);
    chk("e_b",     lastb, 30);
    chk("e_p",     lastp, 100);

    // random input phase, 50/100 pattern
    hold(0, 20);
    jtog(1, 1);
    for (int i = 0; i < 6; i++) begin
      jtog(0, 50);
      if (i == 0) begin
        clr_track();
        g = gcount;
      end
      jtog(1, 50);
    end
    repeat (5) @(negedge CLK);
    chk("f_count", gcount - g, 6);
    chk("f_bmin_ok", int'(minb >= 49), 1);
    chk("f_bmax_ok", int'(maxb <= 51), 1);
    chk("f_pmin_ok", int'(minp >= 99), 1);
    chk("f_pmax_ok", int'(maxp <= 101), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
